// File: rtl/div_if.sv
// div_if: execute-stage <-> divider handshake and operand bundle
interface div_if #(parameter int WIDTH = 32);
  logic signed_div_i;
  logic [WIDTH-1:0] opdata1_i;
  logic [WIDTH-1:0] opdata2_i;
  logic start_i;
  logic annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic ready_o;
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for DIV/DIVU, result {remainder, quotient}
module div_seq #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  div_if.slave d
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] work, result;
  logic [WIDTH-1:0] dvs, quo, rem, abs1, abs2;
  logic [WIDTH:0] trial;
  logic sg, n1, n2, ready, go, done;
  assign go = d.start_i && !d.annul_i;
  assign done = cnt == CW'(WIDTH);
  assign abs1 = d.signed_div_i && d.opdata1_i[WIDTH-1] ? -d.opdata1_i : d.opdata1_i;
  assign abs2 = d.signed_div_i && d.opdata2_i[WIDTH-1] ? -d.opdata2_i : d.opdata2_i;
  // partial remainder stays below the divisor, so WIDTH+1 bits hold the trial and its sign
  assign trial = work[2*WIDTH-1:WIDTH-1] - {1'b0, dvs};
  assign quo = sg && (n1 ^ n2) ? -work[WIDTH-1:0] : work[WIDTH-1:0];
  assign rem = sg && n1 ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
  assign d.result_o = result;
  assign d.ready_o = ready;
  always_comb begin
    state_n = state;
    unique case (state)
      FREE:   state_n = go ? (d.opdata2_i == '0 ? BYZERO : ON) : FREE;
      BYZERO: state_n = END;
      ON:     state_n = !go ? FREE : done ? END : ON;
      END:    state_n = go ? END : FREE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FREE;
      cnt <= '0;
      work <= '0;
      dvs <= '0;
      sg <= 1'b0;
      n1 <= 1'b0;
      n2 <= 1'b0;
      ready <= 1'b0;
      result <= '0;
    end else begin
      state <= state_n;
      ready <= (state == ON && go && done) || (state == END && go);
      // divide-by-zero reaches END with result already cleared; END only holds
      result <= state == ON && go && done ? {rem, quo} : state == END && go ? result : '0;
      if (state == FREE && go) begin
        work <= {{WIDTH{1'b0}}, abs1};
        dvs <= abs2;
        sg <= d.signed_div_i;
        n1 <= d.opdata1_i[WIDTH-1];
        n2 <= d.opdata2_i[WIDTH-1];
        cnt <= '0;
      end else if (state == ON && go && !done) begin
        work <= trial[WIDTH] ? {work[2*WIDTH-2:0], 1'b0} : {trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
